// File: rtl/fetch_stage.sv
// IF stage with IF/ID pipeline register, req/ack instruction fetch, freeze stall and branch flush.
// Optional performance counters are compiled in when FETCH_PERF_EN is defined.
`timescale 1ns/1ps
module fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_id_valid,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [INSTR_W-1:0] if_id_instr
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DRAIN} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  target;
    logic [ADDR_W-1:0]  hold_pc;
    logic [INSTR_W-1:0] hold_instr;
    logic [ADDR_W-1:0]  pc_plus4;
    logic               fetch_done;
    logic               outstanding;

    // pc stays on the old address while draining, so it doubles as the fetch address.
    assign imem_addr   = pc;
    assign pc_plus4    = pc + ADDR_W'(4);
    assign fetch_done  = imem_req && imem_ack;
    assign outstanding = imem_req && !imem_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            target      <= '0;
            hold_pc     <= '0;
            hold_instr  <= '0;
            imem_req    <= 1'b0;
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_instr <= '0;
        end else if (branch_taken) begin
            if_id_valid <= 1'b0;
            if_id_instr <= '0;
            imem_req    <= 1'b1;
            // An unanswered request must complete before the redirect target is fetched.
            if (outstanding) begin
                target <= branch_addr;
                state  <= S_DRAIN;
            end else begin
                pc    <= branch_addr;
                state <= S_FETCH;
            end
        end else begin
            case (state)
                S_FETCH: begin
                    if (fetch_done) begin
                        if (freeze) begin
                            hold_pc    <= pc_plus4;
                            hold_instr <= imem_rdata;
                            imem_req   <= 1'b0;
                            state      <= S_HOLD;
                        end else begin
                            if_id_valid <= 1'b1;
                            if_id_pc    <= pc_plus4;
                            if_id_instr <= imem_rdata;
                            pc          <= pc_plus4;
                            imem_req    <= 1'b1;
                        end
                    end else begin
                        if (!freeze) begin
                            if_id_valid <= 1'b0;
                            if_id_instr <= '0;
                        end
                        imem_req <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!freeze) begin
                        if_id_valid <= 1'b1;
                        if_id_pc    <= hold_pc;
                        if_id_instr <= hold_instr;
                        pc          <= hold_pc;
                        imem_req    <= 1'b1;
                        state       <= S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if_id_valid <= 1'b0;
                    if_id_instr <= '0;
                    imem_req    <= 1'b1;
                    if (fetch_done) begin
                        pc    <= target;
                        state <= S_FETCH;
                    end
                end
                default: begin
                    imem_req <= 1'b0;
                    state    <= S_FETCH;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else if (branch_taken) begin
            perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end else if (freeze) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
